id_ex_hazard_ctrl: RTL and testbench
====================================

// Module: id_ex_hazard_ctrl
// PURPOSE
//  Scoreboard hazard controller that consumes what decode hands to the ID/EX register.
//  Tracks destination registers in flight between ID/EX issue and writeback.
//  Stalls decode on RAW/WAW hazards and flushes IF/ID and ID/EX on a taken branch from EX.
//  Reverses scoreboard entries of the killed younger instruction.
//  Sits beside the ID/EX pipeline register; drives its hold/bubble controls.
// PARAMETERS
//  NREG         64  architectural registers; index width = $clog2(NREG) = 6
//  FLUSH_CYCLES 2   cycles flush stays asserted per taken branch (>=1)
// PORTS
//  clock        in   1  rising-edge clock
//  reset_n      in   1  asynchronous, active-low reset
//  dec_valid    in   1  decode presents an instruction this cycle
//  dec_rs       in   6  source-1 register index
//  dec_rt       in   6  source-2 register index
//  dec_uses_rs  in   1  instruction reads rs
//  dec_uses_rt  in   1  instruction reads rt
//  dec_rd       in   6  destination register index (same field ID/EX latches)
//  dec_wr_rd    in   1  instruction writes rd
//  wb_valid     in   1  writeback retires a register write this cycle
//  wb_rd        in   6  register written back
//  ex_br_taken  in   1  branch in EX resolved taken
//  stall        out  1  hold PC and IF/ID; insert bubble into ID/EX
//  issue        out  1  dec_valid & ~stall & ~flush: instruction enters ID/EX
//  flush        out  1  zero IF/ID and ID/EX contents this cycle
//  pending      out 64  scoreboard vector; bit i = write to reg i in flight
// BEHAVIOUR
//  Reset (async, reset_n=0): pending=0, flush_cnt=0, last_vld=0. Outputs: stall=0, issue=0, flush=0.
//  Hazard (comb): raw = (uses_rs & pending[rs]) | (uses_rt & pending[rt]).
//   waw = wr_rd & pending[rd]. stall = dec_valid & (raw|waw) & ~flush.
//  Flush (comb+seq): flush = ex_br_taken | (flush_cnt!=0).
//   If ex_br_taken: flush_cnt <= FLUSH_CYCLES-1. Else if flush_cnt!=0: decrement.
//   A new ex_br_taken while flush_cnt!=0 reloads the counter (no accumulation).
//  Issue: issue = dec_valid & ~stall & ~flush; zero-latency, same cycle as decode.
//  Scoreboard update (posedge; all terms evaluated on pre-edge values):
//   set   = issue & dec_wr_rd                       -> bit dec_rd
//   clr_w = wb_valid                                -> bit wb_rd
//   clr_k = ex_br_taken & last_vld & last_wr        -> bit last_rd (killed ID/EX occupant)
//   set wins over any clear of the same index (newer writer owns the bit).
//   Clearing an already-clear bit is a no-op; wb to a non-pending reg is not an error.
//  last_vld/last_rd/last_wr capture the instruction issued this cycle.
//   last_vld <= issue & ~ex_br_taken. Any non-issue cycle clears last_vld.
//  Same-cycle forwarding: wb_valid to reg X does not unblock a decode reading X that cycle.
//   Stall releases the next cycle; the RF is write-before-read from the following cycle.
//  Only one write per reg can be in flight (waw stall) so one bit per register suffices.
//  Mid-operation reset: every in-flight tracking is lost; pending returns to 0 immediately.
// STRUCTURE
//  Shared package cpu_pkg: localparam NREG, REG_W, FLUSH_CYCLES default; typedef reg_idx_t [5:0].
//  One sub-module, hazard_scoreboard: pending vector with set/clr_w/clr_k ports and set priority.
//  Flush counter and last-issue capture stay in the top; hazard compare is comb logic in the top.
// TESTING
//  Issue wr r5; next cycle decode reads rs=r5 -> stall=1 until wb_valid,wb_rd=5. Stall=0 the cycle after.
//  Issue wr r7 while decode also writes r7 -> waw stall=1; wb r7 -> issue=1, pending[7] stays 1.
//  Issue wr r9, then ex_br_taken next cycle -> flush=1 for 2 cycles, pending[9]=0, issue=0 during flush.
//  Same cycle: issue wr r3 and wb_valid wb_rd=3 (older write) -> pending[3]=1 after the edge.
//  Pending = r1,r2,r4; assert reset_n=0 mid-stream -> pending=0, stall=0, flush=0 asynchronously.
//  ex_br_taken on two consecutive cycles -> flush held 3 cycles total; counter reloaded, not summed.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline constants and types for the ID/EX hazard controller and its scoreboard.
package cpu_pkg;

  localparam int NREG         = 64;
  localparam int REG_W        = $clog2(NREG);
  localparam int FLUSH_CYCLES = 2;

  typedef logic [REG_W-1:0] reg_idx_t;

  // One-hot register mask, all-zero when the request is inactive.
  function automatic logic [NREG-1:0] reg_mask(input logic en, input reg_idx_t idx);
    return en ? (NREG'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue and cleared on writeback or kill.
module hazard_scoreboard
  import cpu_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            i_set_en,
  input  reg_idx_t        i_set_idx,
  input  logic            i_clr_w_en,
  input  reg_idx_t        i_clr_w_idx,
  input  logic            i_clr_k_en,
  input  reg_idx_t        i_clr_k_idx,
  output logic [NREG-1:0] o_pending
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_next;

  // Clears are applied first so a same-index set from the newer writer survives.
  always_comb begin
    // NOTE: default assignment first so every path drives w_next and no latch is inferred.
    w_next = r_pending;
    w_next = w_next & ~reg_mask(i_clr_w_en, i_clr_w_idx);
    w_next = w_next & ~reg_mask(i_clr_k_en, i_clr_k_idx);
    w_next = w_next | reg_mask(i_set_en, i_set_idx);
  end

  // NOTE: non-blocking assignment for state; the vector is plain flops, so it is reset like any register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_pending <= '0;
    else          r_pending <= w_next;
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller: RAW/WAW stall, taken-branch flush window, and scoreboard upkeep.
module id_ex_hazard_ctrl #(
  parameter int FLUSH_CYCLES = cpu_pkg::FLUSH_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    dec_valid,
  input  cpu_pkg::reg_idx_t       dec_rs,
  input  cpu_pkg::reg_idx_t       dec_rt,
  input  logic                    dec_uses_rs,
  input  logic                    dec_uses_rt,
  input  cpu_pkg::reg_idx_t       dec_rd,
  input  logic                    dec_wr_rd,
  input  logic                    wb_valid,
  input  cpu_pkg::reg_idx_t       wb_rd,
  input  logic                    ex_br_taken,
  output logic                    stall,
  output logic                    issue,
  output logic                    flush,
  output logic [cpu_pkg::NREG-1:0] pending
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  logic [CNT_W-1:0]  r_flush_cnt;
  logic              r_last_vld;
  logic              r_last_wr;
  cpu_pkg::reg_idx_t r_last_rd;

  logic w_raw, w_waw, w_flush, w_stall, w_issue, w_kill;

  // Hazards compare against the pre-edge scoreboard, so a same-cycle writeback does not unblock.
  always_comb begin
    w_raw   = (dec_uses_rs & pending[dec_rs]) | (dec_uses_rt & pending[dec_rt]);
    w_waw   = dec_wr_rd & pending[dec_rd];
    w_flush = ex_br_taken | (r_flush_cnt != '0);
    w_stall = dec_valid & (w_raw | w_waw) & ~w_flush;
    w_issue = dec_valid & ~w_stall & ~w_flush;
    w_kill  = ex_br_taken & r_last_vld & r_last_wr;
  end

  // A new taken branch reloads the window rather than extending it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                r_flush_cnt <= '0;
    else if (ex_br_taken)        r_flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
    else if (r_flush_cnt != '0)  r_flush_cnt <= r_flush_cnt - CNT_W'(1);
  end

  // Remembers the current ID/EX occupant so a taken branch can retract its scoreboard bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_vld <= 1'b0;
      r_last_wr  <= 1'b0;
      r_last_rd  <= '0;
    end else begin
      r_last_vld <= w_issue & ~ex_br_taken;
      r_last_wr  <= dec_wr_rd;
      r_last_rd  <= dec_rd;
    end
  end

  hazard_scoreboard u_scoreboard (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_set_en    (w_issue & dec_wr_rd),
    .i_set_idx   (dec_rd),
    .i_clr_w_en  (wb_valid),
    .i_clr_w_idx (wb_rd),
    .i_clr_k_en  (w_kill),
    .i_clr_k_idx (r_last_rd),
    .o_pending   (pending)
  );

  assign stall = w_stall;
  assign issue = w_issue;
  assign flush = w_flush;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Self-checking bench: directed hazard/flush/reset scenarios plus randomized traffic against a behavioural model.
module tb_id_ex_hazard_ctrl;

  localparam int FC = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        dec_valid, dec_uses_rs, dec_uses_rt, dec_wr_rd, wb_valid, ex_br_taken;
  logic [5:0]  dec_rs, dec_rt, dec_rd, wb_rd;
  logic        stall, issue, flush;
  logic [63:0] pending;

  int errors = 0;
  int checks = 0;

  id_ex_hazard_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .dec_valid   (dec_valid),
    .dec_rs      (dec_rs),
    .dec_rt      (dec_rt),
    .dec_uses_rs (dec_uses_rs),
    .dec_uses_rt (dec_uses_rt),
    .dec_rd      (dec_rd),
    .dec_wr_rd   (dec_wr_rd),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .ex_br_taken (ex_br_taken),
    .stall       (stall),
    .issue       (issue),
    .flush       (flush),
    .pending     (pending)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // In-flight writes as a set of registers; flush as "active up to cycle flush_end";
  // the instruction issued in the previous cycle is the one a taken branch kills.
  bit          m_pend [64];
  int          cyc = 0;
  int          flush_end = -1;
  bit          prev_iss = 0;
  bit          prev_wr = 0;
  int          prev_rd = 0;
  bit          e_flush, e_haz, e_stall, e_issue;
  logic [63:0] e_pend;

  always @(negedge clock) begin
    for (int i = 0; i < 64; i++) e_pend[i] = m_pend[i];
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) m_pend[i] = 0;
      flush_end = -1;
      prev_iss  = 0;
      check("rst_pending", pending, 64'd0);
      check("rst_flush", {63'd0, flush}, 64'd0);
      check("rst_stall", {63'd0, stall}, 64'd0);
    end else begin
      e_flush = ex_br_taken || (cyc <= flush_end);
      e_haz   = (dec_uses_rs && m_pend[dec_rs]) || (dec_uses_rt && m_pend[dec_rt]) ||
                (dec_wr_rd && m_pend[dec_rd]);
      e_stall = dec_valid && e_haz && !e_flush;
      e_issue = dec_valid && !e_haz && !e_flush;
      check("m_pending", pending, e_pend);
      check("m_flush", {63'd0, flush}, {63'd0, e_flush});
      check("m_stall", {63'd0, stall}, {63'd0, e_stall});
      check("m_issue", {63'd0, issue}, {63'd0, e_issue});
      if (wb_valid) m_pend[wb_rd] = 0;
      if (ex_br_taken && prev_iss && prev_wr) m_pend[prev_rd] = 0;
      if (e_issue && dec_wr_rd) m_pend[dec_rd] = 1;
      if (ex_br_taken) flush_end = cyc + FC - 1;
      prev_iss = e_issue && !ex_br_taken;
      prev_wr  = dec_wr_rd;
      prev_rd  = int'(dec_rd);
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                       input int rd, input bit wr, input bit wbv, input int wbr, input bit br);
    dec_valid   = v;
    dec_rs      = 6'(rs);
    dec_uses_rs = urs;
    dec_rt      = 6'(rt);
    dec_uses_rt = urt;
    dec_rd      = 6'(rd);
    dec_wr_rd   = wr;
    wb_valid    = wbv;
    wb_rd       = 6'(wbr);
    ex_br_taken = br;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (3) next_cycle();
    reset_n = 1'b1;

    // RAW: issue wr r5, then a reader of r5 stalls until the cycle after writeback
    next_cycle(); drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    sample(); check("raw_issue_wr5", {63'd0, issue}, 64'd1);
    next_cycle(); drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    sample(); check("raw_stall", {63'd0, stall}, 64'd1);
    check("raw_pend5", pending, 64'h20);
    next_cycle(); drive(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
    sample(); check("raw_stall_wb_cycle", {63'd0, stall}, 64'd1);
    next_cycle(); drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    sample(); check("raw_release", {62'd0, stall, issue}, 64'd1);
    check("raw_pend_clear", pending, 64'd0);

    // WAW on r7: stalls, issues after writeback, bit stays owned by the newer writer
    next_cycle(); drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    sample(); check("waw_issue1", {63'd0, issue}, 64'd1);
    next_cycle(); drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    sample(); check("waw_stall", {63'd0, stall}, 64'd1);
    next_cycle(); drive(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
    sample(); check("waw_stall_wb", {63'd0, stall}, 64'd1);
    next_cycle(); drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    sample(); check("waw_issue2", {63'd0, issue}, 64'd1);
    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
    sample(); check("waw_pend7", pending, 64'h80);
    next_cycle(); idle();
    sample(); check("waw_pend_clear", pending, 64'd0);

    // Taken branch kills the r9 writer in ID/EX and blocks issue for two cycles
    next_cycle(); drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    sample(); check("br_issue9", {63'd0, issue}, 64'd1);
    next_cycle(); drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 1);
    sample(); check("br_flush1", {62'd0, flush, issue}, 64'd2);
    check("br_pend9", pending, 64'h200);
    next_cycle(); drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);
    sample(); check("br_flush2", {62'd0, flush, issue}, 64'd2);
    check("br_kill9", pending, 64'd0);
    next_cycle(); drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);
    sample(); check("br_after", {62'd0, flush, issue}, 64'd1);
    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 1, 10, 0);
    next_cycle(); idle();
    sample(); check("br_clean", pending, 64'd0);

    // Same-edge set and writeback of r3: set wins
    next_cycle(); drive(1, 0, 0, 0, 0, 3, 1, 1, 3, 0);
    sample(); check("sw_issue3", {63'd0, issue}, 64'd1);
    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    sample(); check("sw_pend3", pending, 64'h8);
    next_cycle(); idle();
    sample(); check("sw_clean", pending, 64'd0);

    // Back-to-back taken branches: window reloaded, three flush cycles total
    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    sample(); check("bb_flush1", {63'd0, flush}, 64'd1);
    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    sample(); check("bb_flush2", {63'd0, flush}, 64'd1);
    next_cycle(); idle();
    sample(); check("bb_flush3", {63'd0, flush}, 64'd1);
    next_cycle(); idle();
    sample(); check("bb_flush_off", {63'd0, flush}, 64'd0);

    // Pending r1,r2,r4 then asynchronous reset mid-cycle
    next_cycle(); drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    next_cycle(); drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    next_cycle(); drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    next_cycle(); drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    sample(); check("ar_pend", pending, 64'h16);
    check("ar_stall", {63'd0, stall}, 64'd1);
    #1; reset_n = 1'b0; idle();
    #1; check("ar_pend_zero", pending, 64'd0);
    check("ar_outs_zero", {62'd0, stall, flush}, 64'd0);
    repeat (2) next_cycle();
    reset_n = 1'b1;

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 4000; n++) begin
      next_cycle();
      if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0; idle();
        repeat (2) next_cycle();
        reset_n = 1'b1;
      end
      drive($urandom_range(0, 9) < 7,
            int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) < 4, int'($urandom_range(0, 7)),
            $urandom_range(0, 11) == 0);
    end
    next_cycle(); idle();
    repeat (3) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
